multicycle_main_controller: RTL

- Multi-cycle main control FSM for the MIPS core; sits directly upstream of the ALU function decoder.
- Decodes the instruction opcode over several cycles and drives the datapath mux selects, write enables and the 2-bit alu_option that the ALU decoder consumes.
- Supports lw, sw, R-type, beq, addi, j and ori.
- Waits on a memory ready handshake for instruction fetch, load and store.

---
 rtl/mips_ctrl_pkg.sv | 80 ++++++++
 rtl/ctrl_output_rom.sv | 73 +++++++
 rtl/multicycle_main_controller.sv | 76 +++++++
 3 files changed

// File: rtl/mips_ctrl_pkg.sv
// mips_ctrl_pkg: shared state, opcode and select encodings for the multicycle main controller.
// MAIN_CTRL_BNE_EN adds the BNE state to the opcode decode.
package mips_ctrl_pkg;

   typedef enum logic [3:0] {
      S_FETCH   = 4'd0,
      S_DECODE  = 4'd1,
      S_MEMADR  = 4'd2,
      S_MEMRD   = 4'd3,
      S_MEMWB   = 4'd4,
      S_MEMWR   = 4'd5,
      S_EXECUTE = 4'd6,
      S_ALUWB   = 4'd7,
      S_BEQ     = 4'd8,
      S_ADDIEX  = 4'd9,
      S_ORIEX   = 4'd10,
      S_IWB     = 4'd11,
      S_JUMP    = 4'd12,
      S_BNE     = 4'd13
   } ctrl_state_t;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_ORI   = 6'b001101;
   localparam logic [5:0] OP_J     = 6'b000010;

   localparam logic [1:0] ALUOPT_ADD   = 2'b00;
   localparam logic [1:0] ALUOPT_SUB   = 2'b01;
   localparam logic [1:0] ALUOPT_RTYPE = 2'b10;
   localparam logic [1:0] ALUOPT_OR    = 2'b11;

   localparam logic [1:0] SRCB_B      = 2'b00;
   localparam logic [1:0] SRCB_FOUR   = 2'b01;
   localparam logic [1:0] SRCB_IMM    = 2'b10;
   localparam logic [1:0] SRCB_IMMSH2 = 2'b11;

   localparam logic [1:0] PCSRC_ALU    = 2'b00;
   localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
   localparam logic [1:0] PCSRC_JUMP   = 2'b10;

   // Raw per-state controls; the top applies mem_ready/zero gating and reset forcing.
   typedef struct packed {
      logic       mem_req;
      logic       mem_write;
      logic       ir_write;
      logic       pc_write;
      logic       branch;
      logic       branch_ne;
      logic       i_or_d;
      logic       reg_write;
      logic       reg_dst;
      logic       mem_to_reg;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic       imm_zero_ext;
      logic [1:0] pc_src;
      logic [1:0] alu_option;
   } ctrl_out_t;

   // DECODE successor; S_FETCH marks an opcode this core does not implement.
   function automatic ctrl_state_t decode_next(input logic [5:0] op);
      case (op)
         OP_LW, OP_SW: return S_MEMADR;
         OP_RTYPE:     return S_EXECUTE;
         OP_BEQ:       return S_BEQ;
         OP_ADDI:      return S_ADDIEX;
         OP_ORI:       return S_ORIEX;
         OP_J:         return S_JUMP;
`ifdef MAIN_CTRL_BNE_EN
         OP_BNE:       return S_BNE;
`endif
         default:      return S_FETCH;
      endcase
   endfunction

endpackage

// File: rtl/ctrl_output_rom.sv
// ctrl_output_rom: Moore state -> control vector decode for the multicycle main controller.
// MAIN_CTRL_BNE_EN makes the BNE state decode like BEQ with an inverted branch condition.
module ctrl_output_rom
   import mips_ctrl_pkg::*;
(
   input  ctrl_state_t state_i,
   output ctrl_out_t   ctrl_o
);

   always_comb begin
      ctrl_o = '0;
      case (state_i)
         S_FETCH: begin
            ctrl_o.mem_req   = 1'b1;
            ctrl_o.ir_write  = 1'b1;
            ctrl_o.pc_write  = 1'b1;
            ctrl_o.alu_src_b = SRCB_FOUR;
         end
         S_DECODE: ctrl_o.alu_src_b = SRCB_IMMSH2;
         S_MEMADR: begin
            ctrl_o.alu_src_a = 1'b1;
            ctrl_o.alu_src_b = SRCB_IMM;
         end
         S_MEMRD: begin
            ctrl_o.mem_req = 1'b1;
            ctrl_o.i_or_d  = 1'b1;
         end
         S_MEMWB: begin
            ctrl_o.reg_write  = 1'b1;
            ctrl_o.mem_to_reg = 1'b1;
         end
         S_MEMWR: begin
            ctrl_o.mem_req   = 1'b1;
            ctrl_o.mem_write = 1'b1;
            ctrl_o.i_or_d    = 1'b1;
         end
         S_EXECUTE: begin
            ctrl_o.alu_src_a  = 1'b1;
            ctrl_o.alu_src_b  = SRCB_B;
            ctrl_o.alu_option = ALUOPT_RTYPE;
         end
         S_ALUWB: begin
            ctrl_o.reg_write = 1'b1;
            ctrl_o.reg_dst   = 1'b1;
         end
`ifdef MAIN_CTRL_BNE_EN
         S_BEQ, S_BNE: begin
`else
         S_BEQ: begin
`endif
            ctrl_o.alu_src_a  = 1'b1;
            ctrl_o.alu_src_b  = SRCB_B;
            ctrl_o.alu_option = ALUOPT_SUB;
            ctrl_o.pc_src     = PCSRC_ALUOUT;
            ctrl_o.branch     = 1'b1;
            ctrl_o.branch_ne  = (state_i == S_BNE);
         end
         S_ADDIEX, S_ORIEX: begin
            ctrl_o.alu_src_a    = 1'b1;
            ctrl_o.alu_src_b    = SRCB_IMM;
            ctrl_o.alu_option   = (state_i == S_ORIEX) ? ALUOPT_OR : ALUOPT_ADD;
            ctrl_o.imm_zero_ext = (state_i == S_ORIEX);
         end
         S_IWB: ctrl_o.reg_write = 1'b1;
         S_JUMP: begin
            ctrl_o.pc_src   = PCSRC_JUMP;
            ctrl_o.pc_write = 1'b1;
         end
         default: ctrl_o = '0;
      endcase
   end

endmodule

// File: rtl/multicycle_main_controller.sv
// multicycle_main_controller: multi-cycle MIPS main control FSM feeding the ALU decoder.
// Define MAIN_CTRL_BNE_EN to implement bne (opcode 000101); otherwise it is illegal.
module multicycle_main_controller
   import mips_ctrl_pkg::*;
#(
   parameter int RESET_STATE_FETCH = 1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [5:0] opcode,
   input  logic       zero,
   input  logic       mem_ready,
   output logic       mem_req,
   output logic       mem_write,
   output logic       ir_write,
   output logic       pc_en,
   output logic       i_or_d,
   output logic       reg_write,
   output logic       reg_dst,
   output logic       mem_to_reg,
   output logic       alu_src_a,
   output logic [1:0] alu_src_b,
   output logic       imm_zero_ext,
   output logic [1:0] pc_src,
   output logic [1:0] alu_option,
   output logic       illegal_op
);

   // FETCH is the only meaningful reset state.
   localparam ctrl_state_t RST_STATE = (RESET_STATE_FETCH == 1) ? S_FETCH : S_FETCH;

   ctrl_state_t state_q, state_d;
   ctrl_out_t   rom;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= RST_STATE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = S_FETCH;
      case (state_q)
         S_FETCH:           state_d = mem_ready ? S_DECODE : S_FETCH;
         S_DECODE:          state_d = decode_next(opcode);
         S_MEMADR:          state_d = (opcode == OP_LW) ? S_MEMRD : (opcode == OP_SW) ? S_MEMWR : S_FETCH;
         S_MEMRD:           state_d = mem_ready ? S_MEMWB : S_MEMRD;
         S_MEMWR:           state_d = mem_ready ? S_FETCH : S_MEMWR;
         S_EXECUTE:         state_d = S_ALUWB;
         S_ADDIEX, S_ORIEX: state_d = S_IWB;
         default:           state_d = S_FETCH;
      endcase
   end

   ctrl_output_rom u_rom (
      .state_i(state_q),
      .ctrl_o (rom)
   );

   // Enables are held low combinationally while reset is asserted.
   assign mem_req    = rst_n & rom.mem_req;
   assign mem_write  = rst_n & rom.mem_write;
   assign ir_write   = rst_n & rom.ir_write & mem_ready;
   assign pc_en      = rst_n & ((rom.pc_write & (mem_ready | ~rom.mem_req)) | (rom.branch & (zero ^ rom.branch_ne)));
   assign reg_write  = rst_n & rom.reg_write;
   assign illegal_op = rst_n & (state_q == S_DECODE) & (decode_next(opcode) == S_FETCH);

   assign i_or_d       = rom.i_or_d;
   assign reg_dst      = rom.reg_dst;
   assign mem_to_reg   = rom.mem_to_reg;
   assign alu_src_a    = rom.alu_src_a;
   assign alu_src_b    = rom.alu_src_b;
   assign imm_zero_ext = rom.imm_zero_ext;
   assign pc_src       = rom.pc_src;
   assign alu_option   = rom.alu_option;

endmodule
